miriscv_timer: RTL and testbench
================================

// Module: miriscv_timer
//
// PURPOSE
//  Memory-mapped timer/compare peripheral on the core data bus.
//  - Downstream of address_decoder: selected by its req/we outputs; rdata returns through the RDsel mux.
//  - Upstream of interrupt_controller: drives one int_req_i line; receives the matching int_fin_o line.
//  - Provides a prescaled up-counter, a compare match, and one-shot/auto-reload modes.
//
// PARAMETERS
//  CNT_W    32  counter/compare width, 1..32; upper bits read 0, writes ignored
//  PRESC_W  16  prescaler divisor width, 1..32
//
// PORTS
//  clk_i      in   1   system clock
//  rst_n_i    in   1   asynchronous reset, active-low
//  req_i      in   1   access strobe from address_decoder
//  we_i       in   1   1 = write, 0 = read (valid with req_i)
//  be_i       in   4   byte enables for writes
//  addr_i     in   5   byte offset within timer window; bits [1:0] ignored
//  wdata_i    in   32  write data
//  rdata_o    out  32  read data, registered
//  int_req_o  out  1   interrupt request to interrupt_controller (level)
//  int_fin_i  in   1   one-cycle acknowledge pulse from interrupt_controller
//  pwm_o      out  1   PWM output (see CONFIGURATION)
//
// BEHAVIOUR
//  Clocking and reset
//  - One clock; reset asynchronous, active-low.
//  - Reset: all registers 0, rdata_o=0, int_req_o=0, pwm_o=0.
//
//  Register map (word offsets)
//  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN.
//  - 0x04 PRESC.
//  - 0x08 CMP.
//  - 0x0C CNT.
//  - 0x10 STATUS: [0] MATCH, write-1-to-clear.
//  - 0x14 DUTY.
//  - Unmapped offsets: read 0; writes ignored.
//
//  Bus
//  - Write: commits on the cycle req_i & we_i is high, per byte lane.
//  - Read: req_i & !we_i -> rdata_o valid next cycle.
//  - rdata_o holds its value until the next read.
//  - No wait states; every access completes.
//
//  Prescaler
//  - Counts only while EN=1; holds when EN=0.
//  - tick fires when presc_cnt==PRESC, then presc_cnt<=0.
//  - PRESC=0 -> tick every cycle.
//
//  Counter on tick
//  - If CNT==CMP:
//    - set MATCH.
//    - AUTO_RELOAD=1: CNT<=0.
//    - AUTO_RELOAD=0: CNT holds and EN clears (one-shot stop).
//  - Else CNT<=CNT+1, wrapping 2^CNT_W-1 -> 0 with no flag.
//  - Match is evaluated only on tick, so exactly one MATCH per compare event.
//
//  Interrupt
//  - int_req_o = MATCH & IRQ_EN, combinational from flops.
//  - MATCH clears on int_fin_i, or on a write of 1 to STATUS[0].
//  - Set and clear in the same cycle: set wins.
//
//  Collisions
//  - CPU write to CNT in the same cycle as tick: the write wins, and presc_cnt<=0.
//  - Any write to CNT or PRESC resets presc_cnt.
//  - Writing CTRL.EN=0 mid-count freezes CNT/presc_cnt and preserves MATCH.
//  - Reset mid-count: returns all state to reset values immediately.
//
// CONFIGURATION
//  Macro MIRISCV_TIMER_PWM_EN.
//  - Defined:
//    - DUTY register exists.
//    - pwm_o = EN & (CNT < DUTY), registered, 1-cycle latency.
//  - Undefined:
//    - DUTY is unmapped (reads 0; writes ignored).
//    - pwm_o tied 0.
//
// STRUCTURE
//  - miriscv_timer_pkg: register offset localparams, CTRL/STATUS bit-index localparams, ctrl_t packed struct.
//  - Sub-module miriscv_timer_prescaler: EN/PRESC/clear in, tick out.
//  - Register file and counter live in the top.
//
// TESTING
//  1. Reset: rst_n_i low mid-count -> all reads 0, int_req_o=0, pwm_o=0.
//  2. PRESC=3, CMP=4, CTRL=0b111:
//     - MATCH and int_req_o rise 20 cycles after EN.
//     - CNT->0 and counts again.
//  3. One-shot: CTRL=0b101, CMP=2, PRESC=0:
//     - CNT stops at 2, EN reads 0, MATCH=1.
//     - int_fin_i pulse -> int_req_o=0.
//  4. Collision: STATUS W1C coincident with a new match -> MATCH stays 1.
//  5. Collision: CNT write 0x10 on a tick cycle -> CNT=0x10.
//  6. Byte enables: be_i=4'b0010, write 0xAABBCCDD to CMP=0 -> CMP=0x0000CC00.
//     - Read of 0x18 -> 0.
//  7. PWM build: DUTY=2, CMP=3, PRESC=0, auto-reload -> pwm_o repeats 1,1,0,0.
//     - Non-PWM build: pwm_o stays 0.

Source files
------------

// File: rtl/miriscv_timer_pkg.sv
// Shared definitions for the miriscv_timer peripheral: register offsets,
// CTRL/STATUS bit positions, the CTRL register layout and a byte-lane merge helper.
// Optional feature macro used by the peripheral: MIRISCV_TIMER_PWM_EN.
package miriscv_timer_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned ADDR_W = 5;

    // Byte offsets inside the timer window (word aligned)
    localparam logic [ADDR_W-1:0] OFF_CTRL   = 5'h00;
    localparam logic [ADDR_W-1:0] OFF_PRESC  = 5'h04;
    localparam logic [ADDR_W-1:0] OFF_CMP    = 5'h08;
    localparam logic [ADDR_W-1:0] OFF_CNT    = 5'h0C;
    localparam logic [ADDR_W-1:0] OFF_STATUS = 5'h10;
    localparam logic [ADDR_W-1:0] OFF_DUTY   = 5'h14;

    localparam int unsigned CTRL_EN_BIT          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT      = 2;
    localparam int unsigned STATUS_MATCH_BIT     = 0;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // Replace the enabled byte lanes of old with the matching lanes of wdata
    function automatic logic [BUS_W-1:0] be_merge(
        input logic [BUS_W-1:0] old,
        input logic [BUS_W-1:0] wdata,
        input logic [BE_W-1:0]  be
    );
        logic [BUS_W-1:0] res;
        for (int i = 0; i < int'(BE_W); i++) begin
            res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/miriscv_timer_prescaler.sv
// Prescaler for miriscv_timer: divides the clock by (presc + 1) while enabled.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable; the divider holds its phase while low
//   presc      : divisor; 0 gives a tick every cycle
//   clear      : restart the divider phase at 0
//   tick_c     : one-cycle tick, combinational from the divider flop
module miriscv_timer_prescaler #(
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clear,
    output logic               tick_c
);

    logic [PRESC_W-1:0] presc_cnt_q;
    logic [PRESC_W-1:0] presc_cnt_d;

    assign tick_c = en && (presc_cnt_q == presc);

    // Next divider phase; clear overrides counting
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (clear) begin
            presc_cnt_d = '0;
        end else if (tick_c) begin
            presc_cnt_d = '0;
        end else if (en) begin
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/miriscv_timer.sv
// Memory-mapped timer/compare peripheral with prescaler, compare match,
// one-shot / auto-reload modes and a level interrupt.
// Optional PWM output is built when MIRISCV_TIMER_PWM_EN is defined;
// otherwise DUTY is unmapped and pwm_o is tied low.
// Ports:
//   clk_i, rst_n_i    : clock, asynchronous active-low reset
//   req_i, we_i       : access strobe and write select from the address decoder
//   be_i, addr_i      : write byte enables, byte offset (bits [1:0] ignored)
//   wdata_i, rdata_o  : write data, registered read data (held until next read)
//   int_req_o         : MATCH & IRQ_EN, level interrupt request
//   int_fin_i         : acknowledge pulse, clears MATCH
//   pwm_o             : registered PWM output
module miriscv_timer
    import miriscv_timer_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PRESC_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BUS_W-1:0]  wdata_i,
    output logic [BUS_W-1:0]  rdata_o,
    output logic              int_req_o,
    input  logic              int_fin_i,
    output logic              pwm_o
);

    ctrl_t              ctrl_q,  ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cmp_q,   cmp_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               match_q, match_d;
    logic [BUS_W-1:0]   rdata_d;
    logic [BUS_W-1:0]   ctrl_merged;

    logic [ADDR_W-1:0]  addr_word;
    logic               wr, rd;
    logic               wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_status;
    logic               tick;
    logic               tick_match;
    logic               match_clr;
    logic               unused_addr;

`ifdef MIRISCV_TIMER_PWM_EN
    logic [CNT_W-1:0]   duty_q, duty_d;
    logic               wr_duty;
    logic               pwm_q;
`endif

    // Address decode; the two low address bits do not select anything
    assign addr_word   = {addr_i[ADDR_W-1:2], 2'b00};
    assign unused_addr = ^addr_i[1:0];
    assign wr          = req_i && we_i;
    assign rd          = req_i && !we_i;
    assign wr_ctrl     = wr && (addr_word == OFF_CTRL);
    assign wr_presc    = wr && (addr_word == OFF_PRESC);
    assign wr_cmp      = wr && (addr_word == OFF_CMP);
    assign wr_cnt      = wr && (addr_word == OFF_CNT);
    assign wr_status   = wr && (addr_word == OFF_STATUS);
`ifdef MIRISCV_TIMER_PWM_EN
    assign wr_duty     = wr && (addr_word == OFF_DUTY);
`endif

    // Any write to CNT or PRESC restarts the divider phase
    miriscv_timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .en     (ctrl_q.en),
        .presc  (presc_q),
        .clear  (wr_cnt || wr_presc),
        .tick_c (tick)
    );

    assign tick_match  = tick && (cnt_q == cmp_q);
    assign match_clr   = int_fin_i || (wr_status && be_i[0] && wdata_i[STATUS_MATCH_BIT]);
    assign ctrl_merged = be_merge(BUS_W'(ctrl_q), wdata_i, be_i);
    assign int_req_o   = match_q && ctrl_q.irq_en;

    // Register file and counter next state; CPU writes are applied last so they win
    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        match_d = match_q;

        if (tick) begin
            if (cnt_q == cmp_q) begin
                if (ctrl_q.auto_reload) begin
                    cnt_d = '0;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A new compare event outranks a coincident clear
        if (match_clr) begin
            match_d = 1'b0;
        end
        if (tick_match) begin
            match_d = 1'b1;
        end

        if (wr_ctrl) begin
            ctrl_d.en          = ctrl_merged[CTRL_EN_BIT];
            ctrl_d.auto_reload = ctrl_merged[CTRL_AUTO_RELOAD_BIT];
            ctrl_d.irq_en      = ctrl_merged[CTRL_IRQ_EN_BIT];
        end
        if (wr_presc) begin
            presc_d = PRESC_W'(be_merge(BUS_W'(presc_q), wdata_i, be_i));
        end
        if (wr_cmp) begin
            cmp_d = CNT_W'(be_merge(BUS_W'(cmp_q), wdata_i, be_i));
        end
        if (wr_cnt) begin
            cnt_d = CNT_W'(be_merge(BUS_W'(cnt_q), wdata_i, be_i));
        end
    end

    // Read mux; unmapped offsets return 0
    always_comb begin
        rdata_d = '0;
        case (addr_word)
            OFF_CTRL:   rdata_d = BUS_W'(ctrl_q);
            OFF_PRESC:  rdata_d = BUS_W'(presc_q);
            OFF_CMP:    rdata_d = BUS_W'(cmp_q);
            OFF_CNT:    rdata_d = BUS_W'(cnt_q);
            OFF_STATUS: rdata_d = BUS_W'(match_q);
`ifdef MIRISCV_TIMER_PWM_EN
            OFF_DUTY:   rdata_d = BUS_W'(duty_q);
`endif
            default:    rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            cmp_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            rdata_o <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            if (rd) begin
                rdata_o <= rdata_d;
            end
        end
    end

`ifdef MIRISCV_TIMER_PWM_EN
    // DUTY register and registered PWM compare
    always_comb begin
        duty_d = duty_q;
        if (wr_duty) begin
            duty_d = CNT_W'(be_merge(BUS_W'(duty_q), wdata_i, be_i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= ctrl_q.en && (cnt_q < duty_q);
        end
    end

    assign pwm_o = pwm_q;
`else
    assign pwm_o = 1'b0;
`endif

endmodule

// File: tb/tb_miriscv_timer.sv
// Directed self-checking bench for miriscv_timer. Inputs change on the falling
// edge, outputs are sampled on the falling edge. Honours MIRISCV_TIMER_PWM_EN.
module tb_miriscv_timer;

    logic        clk_i;
    logic        rst_n_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        int_req_o;
    logic        int_fin_i;
    logic        pwm_o;

    int errors;
    int checks;

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_PRESC  = 5'h04;
    localparam logic [4:0] A_CMP    = 5'h08;
    localparam logic [4:0] A_CNT    = 5'h0C;
    localparam logic [4:0] A_STATUS = 5'h10;
    localparam logic [4:0] A_DUTY   = 5'h14;

    miriscv_timer #(
        .CNT_W   (32),
        .PRESC_W (16)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .be_i      (be_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .int_req_o (int_req_o),
        .int_fin_i (int_fin_i),
        .pwm_o     (pwm_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // All bus tasks start and end on a falling edge
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        be_i    = be;
        @(negedge clk_i);
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'h0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = a;
        @(negedge clk_i);
        req_i  = 1'b0;
        d      = rdata_o;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [4:0]  regs [6];
        regs = '{A_CTRL, A_PRESC, A_CMP, A_CNT, A_STATUS, A_DUTY};
        do_reset();
        bus_write(A_PRESC, 32'd0, 4'hF);
        bus_write(A_CMP,   32'd5, 4'hF);
        bus_write(A_CTRL,  32'd7, 4'hF);
        repeat (10) @(negedge clk_i);
        checks++;
        if (int_req_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_irq: got %b expected 1", int_req_o);
        end
        bus_read(A_CMP, d);
        checks++;
        if (d !== 32'd5) begin
            errors++;
            $display("FAIL reset_pre_cmp: got %h expected 5", d);
        end
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (rdata_o !== 32'd0 || int_req_o !== 1'b0 || pwm_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rdata=%h irq=%b pwm=%b expected 0/0/0", rdata_o, int_req_o, pwm_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        foreach (regs[i]) begin
            bus_read(regs[i], d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL reset_read_%h: got %h expected 0", regs[i], d);
            end
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRESC, 32'd3, 4'hF);
        bus_write(A_CMP,   32'd4, 4'hF);
        bus_write(A_CTRL,  32'd7, 4'hF);
        repeat (19) @(negedge clk_i);
        checks++;
        if (int_req_o !== 1'b0) begin
            errors++;
            $display("FAIL auto_irq_early: got %b expected 0", int_req_o);
        end
        @(negedge clk_i);
        checks++;
        if (int_req_o !== 1'b1) begin
            errors++;
            $display("FAIL auto_irq_20: got %b expected 1", int_req_o);
        end
        bus_read(A_CNT, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL auto_cnt_reload: got %h expected 0", d);
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL auto_match: got %h expected 1", d);
        end
        repeat (2) @(negedge clk_i);
        bus_read(A_CNT, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL auto_cnt_again: got %h expected 1", d);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRESC, 32'd0, 4'hF);
        bus_write(A_CMP,   32'd2, 4'hF);
        bus_write(A_CTRL,  32'd5, 4'hF);
        repeat (5) @(negedge clk_i);
        bus_read(A_CNT, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL oneshot_cnt: got %h expected 2", d);
        end
        bus_read(A_CTRL, d);
        checks++;
        if (d !== 32'd4) begin
            errors++;
            $display("FAIL oneshot_ctrl: got %h expected 4", d);
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'd1 || int_req_o !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_match: status=%h irq=%b expected 1/1", d, int_req_o);
        end
        int_fin_i = 1'b1;
        @(negedge clk_i);
        int_fin_i = 1'b0;
        checks++;
        if (int_req_o !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_fin: got %b expected 0", int_req_o);
        end
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL oneshot_status_clr: got %h expected 0", d);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRESC, 32'd0, 4'hF);
        bus_write(A_CMP,   32'd3, 4'hF);
        bus_write(A_CTRL,  32'd3, 4'hF);
        repeat (7) @(negedge clk_i);
        bus_write(A_STATUS, 32'd1, 4'hF);   // lands on the second match edge
        bus_write(A_STATUS, 32'd1, 4'hF);   // lands on a non-match edge
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL w1c_plain: got %h expected 0", d);
        end
        do_reset();
        bus_write(A_PRESC, 32'd0, 4'hF);
        bus_write(A_CMP,   32'd3, 4'hF);
        bus_write(A_CTRL,  32'd3, 4'hF);
        repeat (7) @(negedge clk_i);
        bus_write(A_STATUS, 32'd1, 4'hF);
        bus_read(A_STATUS, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL w1c_collision: got %h expected 1", d);
        end
    endtask

    task automatic test_cnt_collision();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRESC, 32'd0,    4'hF);
        bus_write(A_CMP,   32'hFF,   4'hF);
        bus_write(A_CTRL,  32'd1,    4'hF);
        repeat (3) @(negedge clk_i);
        bus_write(A_CNT,   32'h10,   4'hF);
        bus_read(A_CNT, d);
        checks++;
        if (d !== 32'h10) begin
            errors++;
            $display("FAIL cnt_write_wins: got %h expected 10", d);
        end
        bus_read(A_CNT, d);
        checks++;
        if (d !== 32'h11) begin
            errors++;
            $display("FAIL cnt_after_write: got %h expected 11", d);
        end
    endtask

    task automatic test_freeze();
        logic [31:0] d;
        do_reset();
        bus_write(A_PRESC, 32'd0,  4'hF);
        bus_write(A_CMP,   32'hFF, 4'hF);
        bus_write(A_CTRL,  32'd1,  4'hF);
        repeat (4) @(negedge clk_i);
        bus_write(A_CTRL,  32'd0,  4'hF);
        bus_read(A_CNT, d);
        checks++;
        if (d !== 32'd5) begin
            errors++;
            $display("FAIL freeze_cnt: got %h expected 5", d);
        end
        repeat (3) @(negedge clk_i);
        bus_read(A_CNT, d);
        checks++;
        if (d !== 32'd5) begin
            errors++;
            $display("FAIL freeze_hold: got %h expected 5", d);
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] d;
        do_reset();
        bus_write(A_CMP, 32'hAABBCCDD, 4'b0010);
        bus_read(A_CMP, d);
        checks++;
        if (d !== 32'h0000CC00) begin
            errors++;
            $display("FAIL be_cmp: got %h expected 0000cc00", d);
        end
        bus_write(5'h18, 32'hFFFFFFFF, 4'hF);
        bus_read(5'h18, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_18: got %h expected 0", d);
        end
        bus_read(5'h1C, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_1c: got %h expected 0", d);
        end
    endtask

    task automatic test_pwm();
        logic [31:0] d;
        logic [3:0]  pattern;
        do_reset();
        bus_write(A_DUTY,  32'd2, 4'hF);
        bus_write(A_CMP,   32'd3, 4'hF);
        bus_write(A_PRESC, 32'd0, 4'hF);
`ifdef MIRISCV_TIMER_PWM_EN
        pattern = 4'b0011;                  // bit i = expected pwm at phase i
        bus_read(A_DUTY, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL pwm_duty_read: got %h expected 2", d);
        end
`else
        pattern = 4'b0000;
        bus_read(A_DUTY, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL pwm_duty_unmapped: got %h expected 0", d);
        end
`endif
        bus_write(A_CTRL, 32'd3, 4'hF);
        checks++;
        if (pwm_o !== 1'b0) begin
            errors++;
            $display("FAIL pwm_start: got %b expected 0", pwm_o);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            checks++;
            if (pwm_o !== pattern[i % 4]) begin
                errors++;
                $display("FAIL pwm_cycle_%0d: got %b expected %b", i, pwm_o, pattern[i % 4]);
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n_i   = 1'b0;
        req_i     = 1'b0;
        we_i      = 1'b0;
        be_i      = 4'h0;
        addr_i    = 5'h0;
        wdata_i   = 32'h0;
        int_fin_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_w1c_collision();
        test_cnt_collision();
        test_freeze();
        test_byte_enables();
        test_pwm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
